cond_branch_seq: RTL
====================

Name: cond_branch_seq

Overview:
- Program-counter sequencer for the ECP8 core; the issuing end of the condition-evaluation interface.
- Fetches instructions through a request/acknowledge handshake.
- On a branch, drives the 8-bit condition code to the external condition evaluator and samples its 1-bit result the same cycle. Taken branches load the target; otherwise the PC increments.
- Sits between program memory and the COND evaluator.

Parameters:
ADDR_WIDTH, 8, width of PC, fetch address and branch target.
RESET_VECTOR, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
fetch_req  output  1  fetch request, held high in FETCH until acknowledged
fetch_addr  output  ADDR_WIDTH  address of instruction being fetched (equals pc)
fetch_ack  input  1  program memory accepts/returns instruction this cycle
instr_valid  output  1  one-cycle pulse: instruction returned, execution may begin
step  input  1  execution done, no branch: advance PC
br_valid  input  1  execution done with branch request
br_cond  input  8  condition code: bit0 test-zero, bit1 test-sign (bit7), bit2 invert, bits7:3 reserved
br_target  input  ADDR_WIDTH  branch destination
cond_code  output  8  condition code to evaluator (br_cond when br_valid in EXEC, else 0)
cond_result  input  1  evaluator result for cond_code, combinational same cycle
halt  input  1  stop sequencing
taken  output  1  one-cycle pulse: branch taken
halted  output  1  high while in HALTED
pc  output  ADDR_WIDTH  current program counter
taken_cnt  output  8  taken-branch count (optional feature)

Behaviour:
- States: FETCH, EXEC, HALTED. Reset state: FETCH.
- Reset values: pc=RESET_VECTOR, fetch_req=1 in the first cycle after reset (FETCH), instr_valid=0, taken=0, halted=0, taken_cnt=0.
- Reset has priority over every input. Reset mid-fetch or mid-EXEC discards the pending operation; any fetch_ack in the reset cycle is ignored.
- FETCH:
  - fetch_req=1, fetch_addr=pc.
  - On fetch_ack: next cycle instr_valid=1, state EXEC. Latency: ack to instr_valid is 1 cycle.
  - step, br_valid and halt are ignored in FETCH.
- EXEC:
  - fetch_req=0; wait for an event, evaluated in this priority order:
  - 1. halt: state HALTED, pc unchanged.
  - 2. br_valid: cond_code=br_cond combinationally. If cond_result=1: pc<=br_target, taken pulses next cycle. Else pc<=pc+1. Next state FETCH.
  - 3. step: pc<=pc+1, next state FETCH.
  - No event: remain in EXEC, pc held.
- HALTED:
  - halted=1, fetch_req=0, all inputs ignored; exit only via rst.
- Arithmetic:
  - pc+1 is modulo 2^ADDR_WIDTH; 0xFF wraps to 0x00 with no flag.
  - A branch to the current pc is legal and refetches the same address.
- Condition semantics:
  - Expected evaluator result = bit2 XOR ((bit0 AND input==0) OR (bit1 AND input[7])).
  - 0x00 = never, 0x04 = always.
  - The sequencer trusts cond_result and does not recompute it.
- fetch_ack outside FETCH is ignored.
- cond_code is 0 whenever not in EXEC with br_valid=1.

Optional Feature:
- Macro: COND_BRANCH_STATS_EN.
- Defined: taken_cnt increments by 1 on every taken branch, saturating at 0xFF, cleared by rst.
- Undefined: no counter logic; taken_cnt tied to 0.

Test Plan:
- Reset, then fetch_ack every cycle with step one cycle after each instr_valid -> fetch_addr sequence 0x00,0x01,0x02; instr_valid one cycle after each ack.
- pc=0x10, EXEC, br_valid=1, br_cond=0x04, br_target=0x80, cond_result=1 -> cond_code=0x04 that cycle; next cycle pc=0x80, taken=1, fetch_addr=0x80.
- pc=0x10, br_valid=1, br_cond=0x01, cond_result=0 -> pc=0x11, taken=0; same-cycle step=1 with br_valid=1 still yields a single increment.
- pc=0xFF, step -> pc=0x00, fetch_addr=0x00.
- EXEC with halt=1 and br_valid=1 together -> HALTED, pc unchanged, fetch_req=0; later step/fetch_ack ignored; rst -> pc=RESET_VECTOR, FETCH.
- With COND_BRANCH_STATS_EN: 300 taken branches -> taken_cnt=0xFF; rst asserted mid-fetch -> taken_cnt=0, pc=RESET_VECTOR, ack in reset cycle ignored.

Source files
------------

// File: rtl/cond_branch_seq_if.sv
// Fetch, branch and condition-evaluation signals of the ECP8 program-counter sequencer.
// master = sequencer side, slave = program memory / execute stage / condition evaluator side.
interface cond_branch_seq_if #(
  parameter int ADDR_WIDTH = 8
);
  // Fetch handshake: a transfer happens on a rising edge where fetch_req && fetch_ack.
  // fetch_req stays high, with fetch_addr stable, until that edge. fetch_ack is ignored
  // whenever fetch_req is low. instr_valid pulses for one cycle after the transfer.
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ack;
  logic                  instr_valid;
  logic                  step;
  logic                  br_valid;
  logic [7:0]            br_cond;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [7:0]            cond_code;
  logic                  cond_result;
  logic                  halt;
  logic                  taken;
  logic                  halted;
  logic [ADDR_WIDTH-1:0] pc;
  logic [7:0]            taken_cnt;
  logic [1:0]            state_dbg;

  modport master (
    output fetch_req, fetch_addr, instr_valid, cond_code, taken, halted, pc, taken_cnt, state_dbg,
    input  fetch_ack, step, br_valid, br_cond, br_target, cond_result, halt
  );

  modport slave (
    input  fetch_req, fetch_addr, instr_valid, cond_code, taken, halted, pc, taken_cnt, state_dbg,
    output fetch_ack, step, br_valid, br_cond, br_target, cond_result, halt
  );
endinterface

// File: rtl/cond_branch_seq.sv
// Program-counter sequencer for the ECP8 core: fetch handshake, conditional branch, halt.
// Optional taken-branch counter enabled by defining COND_BRANCH_STATS_EN.
module cond_branch_seq #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  cond_branch_seq_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  taken_q, taken_d;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  // EXEC event priority: halt, then branch, then step.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    taken_d       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.fetch_ack) begin
          state_d       = ST_EXEC;
          instr_valid_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (bus.br_valid) begin
          state_d = ST_FETCH;
          if (bus.cond_result) begin
            pc_d    = bus.br_target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end else if (bus.step) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_VECTOR;
      instr_valid_q <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      taken_q       <= taken_d;
    end
  end

  assign bus.fetch_req   = (state_q == ST_FETCH);
  assign bus.fetch_addr  = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.taken       = taken_q;
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.state_dbg   = state_q;
  assign bus.cond_code   = (state_q == ST_EXEC && bus.br_valid) ? bus.br_cond : 8'h00;

`ifdef COND_BRANCH_STATS_EN
  logic [7:0] taken_cnt_q, taken_cnt_d;

  // Counts in step with the taken pulse; sticks at 0xFF.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (taken_d && taken_cnt_q != 8'hFF) begin
      taken_cnt_d = taken_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q <= 8'h00;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.taken_cnt = taken_cnt_q;
`else
  assign bus.taken_cnt = 8'h00;
`endif

endmodule
